// File: rtl/conv_stream_feeder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// conv_stream_feeder
//
// Feeds a sliding-window convolution engine. For each job it first streams
// the KX*KY kernel coefficients out of a kernel memory. It then streams an
// L x L image, row-major from address 0, out of an image memory. It also
// flags every pixel that completes a full KX x KY window.
//
// Row length L = 16 << xres_select (codes 0..4, capped by MAX_RES). Both
// memories have a 1-cycle read latency. Every stream output is registered,
// so each output appears two cycles after the read that produced it.
//
// Ports
//   clock, clock_sreset      : sole clock; asynchronous active-high reset
//   start, xres_select       : job request pulse and row-length code
//   busy, done, error        : job active, job-complete pulse, bad-code pulse
//   hold                     : downstream backpressure; suppresses image reads
//   kern_rd_addr/kern_rd_data: kernel memory read port
//   img_rd_en/img_rd_addr/img_rd_data : image memory read port
//   xres_out                 : row-length code latched for the current job
//   kernel_valid/kernel_data : kernel coefficient stream
//   data_shift/data          : pixel stream
//   enable_calc              : the pixel just shifted completes a full window
//   stall_count              : STREAM cycles lost to hold
//
// Configuration
//   CONV_FEED_PERF_CNT_EN : when defined, builds the saturating stall counter.
//                           When undefined, stall_count is tied to zero.
// -----------------------------------------------------------------------------
module conv_stream_feeder #(
    parameter int EXP     = 8,
    parameter int MANT    = 7,
    parameter int WIDTH   = 1 + EXP + MANT,
    parameter int KX      = 3,
    parameter int KY      = 3,
    parameter int MAX_RES = 256
) (
    input  logic                      clock,
    input  logic                      clock_sreset,
    input  logic                      start,
    input  logic [2:0]                xres_select,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    input  logic                      hold,
    output logic [$clog2(KX*KY)-1:0]  kern_rd_addr,
    input  logic [WIDTH-1:0]          kern_rd_data,
    output logic                      img_rd_en,
    output logic [15:0]               img_rd_addr,
    input  logic [WIDTH-1:0]          img_rd_data,
    output logic [2:0]                xres_out,
    output logic                      kernel_valid,
    output logic [WIDTH-1:0]          kernel_data,
    output logic                      data_shift,
    output logic [WIDTH-1:0]          data,
    output logic                      enable_calc,
    output logic [31:0]               stall_count
);

    localparam int NK  = KX * KY;
    localparam int KAW = $clog2(NK);
    localparam int KCW = $clog2(NK + 2);
    // Wide enough to hold L itself, not only L-1.
    localparam int RW  = $clog2(MAX_RES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_KERNEL,
        STREAM,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [2:0]         xres_q, xres_d;
    logic [RW-1:0]      len_q, len_d;
    logic [15:0]        last_addr_q, last_addr_d;
    logic [KCW-1:0]     kcnt_q, kcnt_d;
    logic [KAW-1:0]     kern_addr_q, kern_addr_d;
    logic               kv_p1_q, kv_p1_d;
    logic               kernel_valid_q, kernel_valid_d;
    logic [WIDTH-1:0]   kernel_data_q, kernel_data_d;
    logic [15:0]        img_addr_q, img_addr_d;
    logic               rd_p1_q, rd_p1_d;
    logic               data_shift_q, data_shift_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [RW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic               enable_calc_q, enable_calc_d;
    logic               last_pix_q, last_pix_d;

    // Row-length decode for the code on xres_select.
    logic [31:0]        len_full;
    logic [31:0]        area_full;
    logic               code_ok;

    always_comb begin
        len_full  = 32'd16 << xres_select;
        // L*L = 2^(8 + 2*code); a 16-bit slice of 65536 is 0, and minus one
        // gives the correct last address 16'hFFFF.
        area_full = 32'd256 << {xres_select, 1'b0};
        code_ok   = (xres_select <= 3'd4) && (len_full <= 32'(MAX_RES));
    end

    // Image reads are issued combinationally so hold takes effect in the
    // same cycle.
    assign img_rd_en = (state_q == STREAM) && !hold;

    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves one
        // unassigned, which would infer a latch.
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        xres_d       = xres_q;
        len_d        = len_q;
        last_addr_d  = last_addr_q;
        kcnt_d       = kcnt_q;
        kern_addr_d  = kern_addr_q;
        kv_p1_d      = 1'b0;
        img_addr_d   = img_addr_q;

        // Two-stage return path: address cycle -> memory data cycle ->
        // registered output. It runs independently of hold, so in-flight
        // reads always complete.
        rd_p1_d        = img_rd_en;
        kernel_valid_d = kv_p1_q;
        kernel_data_d  = kv_p1_q ? kern_rd_data : kernel_data_q;
        data_shift_d   = rd_p1_q;
        data_d         = rd_p1_q ? img_rd_data : data_q;

        // row_q/col_q give the position of the pixel now on data_shift.
        enable_calc_d = data_shift_q && (row_q >= RW'(KY - 1)) && (col_q >= RW'(KX - 1));
        last_pix_d    = data_shift_q && (row_q == len_q - 1'b1) && (col_q == len_q - 1'b1);
        col_d         = col_q;
        row_d         = row_q;
        if (data_shift_q) begin
            if (col_q == len_q - 1'b1) begin
                col_d = '0;
                row_d = (row_q == len_q - 1'b1) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (code_ok) begin
                        state_d     = LOAD_KERNEL;
                        busy_d      = 1'b1;
                        xres_d      = xres_select;
                        len_d       = len_full[RW-1:0];
                        last_addr_d = area_full[15:0] - 16'd1;
                        kcnt_d      = '0;
                        kern_addr_d = '0;
                        img_addr_d  = '0;
                        col_d       = '0;
                        row_d       = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            LOAD_KERNEL: begin
                // kcnt runs 0..NK+1. The first NK cycles issue addresses.
                // The last two wait for the final coefficient to reach
                // kernel_valid.
                kv_p1_d = (kcnt_q < KCW'(NK));
                kcnt_d  = kcnt_q + 1'b1;
                if (kcnt_q < KCW'(NK - 1)) begin
                    kern_addr_d = kern_addr_q + 1'b1;
                end
                if (kcnt_q == KCW'(NK + 1)) begin
                    state_d = STREAM;
                end
            end

            STREAM: begin
                if (!hold) begin
                    if (img_addr_q == last_addr_q) begin
                        state_d = DRAIN;
                    end else begin
                        img_addr_d = img_addr_q + 16'd1;
                    end
                end
            end

            DRAIN: begin
                // last_pix_q rises together with the final enable_calc.
                if (last_pix_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clock or posedge clock_sreset) begin
        if (clock_sreset) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            xres_q         <= '0;
            len_q          <= RW'(16);
            last_addr_q    <= '0;
            kcnt_q         <= '0;
            kern_addr_q    <= '0;
            kv_p1_q        <= 1'b0;
            kernel_valid_q <= 1'b0;
            kernel_data_q  <= '0;
            img_addr_q     <= '0;
            rd_p1_q        <= 1'b0;
            data_shift_q   <= 1'b0;
            data_q         <= '0;
            col_q          <= '0;
            row_q          <= '0;
            enable_calc_q  <= 1'b0;
            last_pix_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            xres_q         <= xres_d;
            len_q          <= len_d;
            last_addr_q    <= last_addr_d;
            kcnt_q         <= kcnt_d;
            kern_addr_q    <= kern_addr_d;
            kv_p1_q        <= kv_p1_d;
            kernel_valid_q <= kernel_valid_d;
            kernel_data_q  <= kernel_data_d;
            img_addr_q     <= img_addr_d;
            rd_p1_q        <= rd_p1_d;
            data_shift_q   <= data_shift_d;
            data_q         <= data_d;
            col_q          <= col_d;
            row_q          <= row_d;
            enable_calc_q  <= enable_calc_d;
            last_pix_q     <= last_pix_d;
        end
    end

`ifdef CONV_FEED_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start && code_ok) begin
            stall_d = '0;
        end else if (state_q == STREAM && hold && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge clock_sreset) begin
        if (clock_sreset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign xres_out     = xres_q;
    assign kern_rd_addr = kern_addr_q;
    assign img_rd_addr  = img_addr_q;
    assign kernel_valid = kernel_valid_q;
    assign kernel_data  = kernel_data_q;
    assign data_shift   = data_shift_q;
    assign data         = data_q;
    assign enable_calc  = enable_calc_q;

endmodule

// File: tb/tb_conv_stream_feeder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_conv_stream_feeder
//
// Bench for conv_stream_feeder. Behavioural kernel and image memories have a
// 1-cycle read latency. When a job starts, the expected kernel and pixel
// streams are queued. A negedge monitor pops and compares them as the DUT
// emits data. It also predicts enable_calc from the pixel position and tallies
// event counts that the main thread checks after each job.
// -----------------------------------------------------------------------------
module tb_conv_stream_feeder;

    localparam int WIDTH = 16;
    localparam int NK    = 9;

    logic               clock;
    logic               clock_sreset;
    logic               start;
    logic [2:0]         xres_select;
    logic               busy, done, error;
    logic               hold;
    logic [3:0]         kern_rd_addr;
    logic [WIDTH-1:0]   kern_rd_data;
    logic               img_rd_en;
    logic [15:0]        img_rd_addr;
    logic [WIDTH-1:0]   img_rd_data;
    logic [2:0]         xres_out;
    logic               kernel_valid;
    logic [WIDTH-1:0]   kernel_data;
    logic               data_shift;
    logic [WIDTH-1:0]   data;
    logic               enable_calc;
    logic [31:0]        stall_count;

    conv_stream_feeder dut (
        .clock        (clock),
        .clock_sreset (clock_sreset),
        .start        (start),
        .xres_select  (xres_select),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .hold         (hold),
        .kern_rd_addr (kern_rd_addr),
        .kern_rd_data (kern_rd_data),
        .img_rd_en    (img_rd_en),
        .img_rd_addr  (img_rd_addr),
        .img_rd_data  (img_rd_data),
        .xres_out     (xres_out),
        .kernel_valid (kernel_valid),
        .kernel_data  (kernel_data),
        .data_shift   (data_shift),
        .data         (data),
        .enable_calc  (enable_calc),
        .stall_count  (stall_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [WIDTH-1:0] pix(input int a);
        return 16'(a * 40503 + 7) ^ 16'(a >> 3);
    endfunction

    function automatic logic [WIDTH-1:0] kern_word(input int i);
        return 16'(16'h3C00 + i * 273);
    endfunction

    // Memory models, 1-cycle read latency.
    always @(posedge clock) begin
        kern_rd_data <= kern_word(int'(kern_rd_addr));
        if (img_rd_en) img_rd_data <= pix(int'(img_rd_addr));
    end

    // ---------------------------------------------------------------- checking
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // ----------------------------------------------------------------- monitor
    // Main thread requests a new expectation set by bumping job_id.
    int job_id  = 0;
    int job_len = 16;

    int seen_job = 0;
    int mon_len  = 16;
    int p_idx    = 0;
    bit exp_en_next = 1'b0;
    logic [WIDTH-1:0] kq[$];
    logic [WIDTH-1:0] dq[$];

    int cyc = 0;
    int n_rd = 0, n_kv = 0, n_sh = 0, n_en = 0, n_dn = 0, n_er = 0;
    int hold_viol = 0, kern_bad = 0, data_bad = 0, en_bad = 0, done_busy_bad = 0;
    int last_rd_addr = 0, last_en_cyc = 0, done_cyc = 0;

    always @(negedge clock) begin
        logic [WIDTH-1:0] e;
        int r, c;
        cyc++;
        if (clock_sreset) begin
            exp_en_next = 1'b0;
        end else begin
            if (job_id != seen_job) begin
                seen_job = job_id;
                mon_len  = job_len;
                p_idx    = 0;
                kq.delete();
                dq.delete();
                for (int i = 0; i < NK; i++) kq.push_back(kern_word(i));
                for (int a = 0; a < mon_len * mon_len; a++) dq.push_back(pix(a));
            end
            if (img_rd_en) begin
                n_rd++;
                last_rd_addr = int'(img_rd_addr);
                if (hold) hold_viol++;
            end
            if (kernel_valid) begin
                n_kv++;
                if (kq.size() == 0) kern_bad++;
                else begin
                    e = kq.pop_front();
                    if (kernel_data !== e) kern_bad++;
                end
            end
            if (enable_calc !== exp_en_next) en_bad++;
            if (enable_calc) begin
                n_en++;
                last_en_cyc = cyc;
            end
            exp_en_next = 1'b0;
            if (data_shift) begin
                n_sh++;
                if (dq.size() == 0) data_bad++;
                else begin
                    e = dq.pop_front();
                    if (data !== e) data_bad++;
                end
                r = p_idx / mon_len;
                c = p_idx % mon_len;
                exp_en_next = (r >= 2) && (c >= 2);
                p_idx++;
            end
            if (done) begin
                n_dn++;
                done_cyc = cyc;
                if (busy) done_busy_bad++;
            end
            if (error) n_er++;
        end
    end

    typedef struct {
        int rd, kv, sh, en, dn, er, hv, kb, db, eb, dbb;
    } snap_t;

    function automatic snap_t take_snap();
        snap_t s;
        s.rd = n_rd; s.kv = n_kv; s.sh = n_sh; s.en = n_en; s.dn = n_dn; s.er = n_er;
        s.hv = hold_viol; s.kb = kern_bad; s.db = data_bad; s.eb = en_bad; s.dbb = done_busy_bad;
        return s;
    endfunction

    // --------------------------------------------------------------- stimulus
    task automatic start_job(input int code);
        @(posedge clock); #1;
        start       = 1'b1;
        xres_select = 3'(code);
        if (code <= 4) begin
            job_len = 16 << code;
            job_id++;
        end
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},         busy,         0);
        check({tag, " done"},         done,         0);
        check({tag, " error"},        error,        0);
        check({tag, " img_rd_en"},    img_rd_en,    0);
        check({tag, " img_rd_addr"},  img_rd_addr,  0);
        check({tag, " kern_rd_addr"}, kern_rd_addr, 0);
        check({tag, " kernel_valid"}, kernel_valid, 0);
        check({tag, " kernel_data"},  kernel_data,  0);
        check({tag, " data_shift"},   data_shift,   0);
        check({tag, " data"},         data,         0);
        check({tag, " enable_calc"},  enable_calc,  0);
        check({tag, " xres_out"},     xres_out,     0);
        check({tag, " stall_count"},  stall_count,  0);
    endtask

    // Runs one job to completion with optional hold window, random hold, or a
    // stray start pulse partway through the stream, then checks the totals.
    task automatic run_job(input string tag, input int code, input int hold_at,
                           input int hold_len, input bit rand_hold, input int restart_at);
        snap_t b;
        int    hcnt = 0;
        bit    fin  = 1'b0;
        int    len  = 16 << code;
        int    area = len * len;
        int    nen  = (len - 2) * (len - 2);
        b = take_snap();
        start_job(code);
        for (int i = 0; i < 2 * area + 400 && !fin; i++) begin
            @(posedge clock); #1;
            hold = 1'b0;
            if (hold_len > 0 && (n_rd - b.rd) >= hold_at && hcnt < hold_len) begin
                hold = 1'b1;
                hcnt++;
            end
            if (rand_hold && $urandom_range(3) == 0) hold = 1'b1;
            start       = (restart_at > 0) && ((n_rd - b.rd) == restart_at);
            xres_select = start ? 3'd2 : 3'(code);
            if (n_dn != b.dn) fin = 1'b1;
        end
        hold  = 1'b0;
        start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check({tag, " finished"},        fin,                    1);
        check({tag, " kernel_valid n"},  n_kv - b.kv,            NK);
        check({tag, " kernel_data"},     kern_bad - b.kb,        0);
        check({tag, " img_rd_en n"},     n_rd - b.rd,            area);
        check({tag, " last rd addr"},    last_rd_addr,           area - 1);
        check({tag, " data_shift n"},    n_sh - b.sh,            area);
        check({tag, " data order"},      data_bad - b.db,        0);
        check({tag, " enable_calc n"},   n_en - b.en,            nen);
        check({tag, " enable timing"},   en_bad - b.eb,          0);
        check({tag, " done n"},          n_dn - b.dn,            1);
        check({tag, " done latency"},    done_cyc - last_en_cyc, 1);
        check({tag, " busy at done"},    done_busy_bad - b.dbb,  0);
        check({tag, " busy after"},      busy,                   0);
        check({tag, " read under hold"}, hold_viol - b.hv,       0);
        check({tag, " xres_out"},        xres_out,               code);
    endtask

    initial begin
        snap_t b;
        bit    reached;
        int    exp_stall;

        clock_sreset = 1'b1;
        start        = 1'b0;
        xres_select  = '0;
        hold         = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("por");
        clock_sreset = 1'b0;

        // Plain job, smallest frame.
        run_job("j16", 0, 0, 0, 1'b0, 0);
        check("j16 stall_count", stall_count, 0);

        // Ten-cycle hold in the middle of row 5.
        run_job("hold", 0, 88, 10, 1'b0, 0);
`ifdef CONV_FEED_PERF_CNT_EN
        exp_stall = 10;
`else
        exp_stall = 0;
`endif
        check("hold stall_count", stall_count, exp_stall);

        // Invalid row-length code.
        b = take_snap();
        @(posedge clock); #1;
        start       = 1'b1;
        xres_select = 3'd5;
        @(posedge clock); #1;
        start = 1'b0;
        check("err busy next", busy, 0);
        repeat (5) @(posedge clock);
        #1;
        check("err pulses",     n_er - b.er, 1);
        check("err no img rd",  n_rd - b.rd, 0);
        check("err no kernel",  n_kv - b.kv, 0);
        check("err busy",       busy,        0);

        // Stray start while streaming must be ignored.
        run_job("restart", 0, 0, 0, 1'b0, 50);

        // Reset after the 100th data_shift.
        b = take_snap();
        start_job(0);
        reached = 1'b0;
        for (int i = 0; i < 600 && !reached; i++) begin
            @(posedge clock); #1;
            if ((n_sh - b.sh) >= 100) reached = 1'b1;
        end
        check("rst reached 100 shifts", reached, 1);
        clock_sreset = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (3) @(posedge clock);
        #1;
        clock_sreset = 1'b0;
        b = take_snap();
        repeat (30) @(posedge clock);
        #1;
        check("post-rst data_shift", n_sh - b.sh, 0);
        check("post-rst enable",     n_en - b.en, 0);
        check("post-rst done",       n_dn - b.dn, 0);
        check("post-rst reads",      n_rd - b.rd, 0);
        run_job("afterrst", 0, 0, 0, 1'b0, 0);

        // Random backpressure on a 32x32 frame.
        run_job("j32rand", 1, 0, 0, 1'b1, 0);

        // Largest frame.
        run_job("j256", 4, 0, 0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_stream_feeder.md
CONV_STREAM_FEEDER -- requirements
Module: conv_stream_feeder

Interface
REQ-001 SHALL have parameters (name, default, meaning): EXP 8 exponent bits; MANT 7 mantissa bits; WIDTH 1+EXP+MANT word width; KX 3 kernel width; KY 3 kernel height; MAX_RES 256 largest row length.
REQ-002 SHALL have ports (name, direction, width, meaning): clock in 1 sole clock; clock_sreset in 1 reset, asynchronous, active-high.
REQ-003 SHALL have ports: start in 1 job request pulse; xres_select in 3 row-length code; busy out 1 job active; done out 1 job-complete pulse; error out 1 invalid-code pulse.
REQ-004 SHALL have ports: hold in 1 downstream backpressure; kern_rd_addr out $clog2(KX*KY) kernel memory address; kern_rd_data in WIDTH kernel word; img_rd_en out 1 image read strobe; img_rd_addr out 16 image address; img_rd_data in WIDTH pixel.
REQ-005 SHALL have ports toward the convolution engine: xres_out out 3 latched code; kernel_valid out 1; kernel_data out WIDTH; data_shift out 1; data out WIDTH; enable_calc out 1; stall_count out 32 performance counter.

Function
REQ-006 Row length L SHALL be 16<<code for xres_select 0..4; frame SHALL be L x L pixels, row-major, image address 0 first.
REQ-007 FSM states SHALL be IDLE, LOAD_KERNEL, STREAM, DRAIN; start is honoured only in IDLE and ignored otherwise.
REQ-008 start in IDLE with xres_select>4 SHALL pulse error for one cycle and remain in IDLE; busy stays 0.
REQ-009 Valid start SHALL latch xres_select into xres_out (constant until next job), set busy the next cycle, and enter LOAD_KERNEL.
REQ-010 LOAD_KERNEL SHALL issue kern_rd_addr 0..KX*KY-1 on consecutive cycles; both memories have 1-cycle read latency.
REQ-011 kernel_valid SHALL assert exactly KX*KY cycles, each 2 cycles after its address, with kernel_data equal to the registered kern_rd_data, in address order.
REQ-012 STREAM SHALL begin the cycle after the last kernel_valid; each cycle with hold low it issues img_rd_en with the next address, until address L*L-1 is issued.
REQ-013 hold high SHALL suppress img_rd_en in that cycle only; at most 2 in-flight reads complete normally; order and count are preserved.
REQ-014 Read issued in cycle t SHALL produce data_shift=1 and data=pixel in cycle t+2 (registered); exactly L*L data_shift pulses per job.
REQ-015 For a pixel at row r, column c with r>=KY-1 and c>=KX-1, enable_calc SHALL pulse one cycle after its data_shift; otherwise it stays 0; (L-KY+1)*(L-KX+1) pulses per job.
REQ-016 After the last read, DRAIN SHALL wait for the final data_shift/enable_calc, then pulse done one cycle after the last enable_calc, clear busy that same cycle, and return to IDLE.
REQ-017 Address counters SHALL not wrap within a job; row/column counters SHALL wrap at L.

Reset
REQ-018 clock_sreset SHALL asynchronously force IDLE and drive busy, done, error, img_rd_en, img_rd_addr, kern_rd_addr, kernel_valid, kernel_data, data_shift, data, enable_calc, xres_out, and stall_count to 0.
REQ-019 Reset mid-job SHALL discard in-flight reads; no data_shift, enable_calc, or done SHALL appear after reset release until a new start.

Configuration
REQ-020 With CONV_FEED_PERF_CNT_EN defined, stall_count SHALL clear on valid start and increment each STREAM cycle with hold high, saturating at 2^32-1.
REQ-021 Without CONV_FEED_PERF_CNT_EN, stall_count SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-022 xres_select=0, hold=0 -> 9 kernel_valid (addresses 0..8), 256 data_shift in address order, 196 enable_calc, one done, last img_rd_addr=255.
REQ-023 xres_select=0, hold high 10 cycles mid-row 5 -> no img_rd_en during hold, still 256 shifts/196 enables, data order intact, stall_count=10 with macro, 0 without.
REQ-024 xres_select=5 with start -> error pulses once, busy=0, no memory reads.
REQ-025 start re-asserted during STREAM -> ignored; counts of REQ-022 unchanged, xres_out unchanged.
REQ-026 clock_sreset asserted after 100th data_shift -> all outputs 0 immediately; a new start then completes with REQ-022 counts.
REQ-027 xres_select=4 -> 65536 data_shift, 64516 enable_calc, last img_rd_addr=65535, one done.
